// File: rtl/ripple_carry_adder_if.sv
// Operand/result bundle for the registered ripple-carry adder.
// The master launches adds; the slave (the adder) returns registered results.
interface ripple_carry_adder_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin,
        input  out_valid, s, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin,
        output out_valid, s, cout, ovf, zero
    );
endinterface

// File: rtl/ripple_carry_adder.sv
// Registered N-bit ripple-carry adder: {cout,s} = a + b + cin, one cycle of latency.
// A chain of full-adder cells feeds a single bank of output registers.
module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ripple_carry_adder_if.slave  bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;

    assign c[0] = bus.cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]  = bus.a[i] ^ bus.b[i] ^ c[i];
        assign c[i+1]  = (bus.a[i] & bus.b[i]) | (c[i] & (bus.a[i] ^ bus.b[i]));
    end

    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.s         <= '0;
            bus.cout      <= 1'b0;
            bus.ovf       <= 1'b0;
            bus.zero      <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            // Result registers only load on a launch, so X operands while idle never reach them.
            if (bus.in_valid) begin
                bus.s    <= sum;
                bus.cout <= c[WIDTH];
                bus.ovf  <= c[WIDTH] ^ c[WIDTH-1];
                bus.zero <= ~|sum;
            end
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder: directed steps plus an exhaustive sweep
// compared against an arithmetic reference model.
module tb_ripple_carry_adder;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ripple_carry_adder_if #(.WIDTH(W)) bus ();
    ripple_carry_adder #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
        logic         zero;
    } res_t;

    // Reference: plain unsigned sum for {cout,s}, signed range test for overflow.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        res_t        r;
        int unsigned u;
        int          sg;
        u      = int'(a) + int'(b) + int'(cin);
        sg     = int'($signed(a)) + int'($signed(b)) + int'(cin);
        r.s    = u[W-1:0];
        r.cout = u[W];
        r.ovf  = (sg > (2 ** (W - 1)) - 1) || (sg < -(2 ** (W - 1)));
        r.zero = (u[W-1:0] == '0);
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input res_t exp);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, ".s"},         32'(bus.s),         32'(exp.s));
        check({tag, ".cout"},      32'(bus.cout),      32'(exp.cout));
        check({tag, ".ovf"},       32'(bus.ovf),       32'(exp.ovf));
        check({tag, ".zero"},      32'(bus.zero),      32'(exp.zero));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".s"},         32'(bus.s),         32'd0);
        check({tag, ".cout"},      32'(bus.cout),      32'd0);
        check({tag, ".ovf"},       32'(bus.ovf),       32'd0);
        check({tag, ".zero"},      32'(bus.zero),      32'd0);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        bus.in_valid = v;
        bus.a        = a;
        bus.b        = b;
        bus.cin      = cin;
    endtask

    // Called just after a falling edge: launch, wait one cycle, compare.
    task automatic add_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin);
        drive(1'b1, a, b, cin);
        @(negedge clk);
        check_result(tag, model(a, b, cin));
    endtask

    initial begin
        logic [2*W:0] vec;
        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0);

        // Reset state
        repeat (2) @(negedge clk);
        check_cleared("reset");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_cleared("idle_after_reset");
        end

        // Directed adds
        add_and_check("add_1101_1011_1", 4'b1101, 4'b1011, 1'b1);
        check("add_1101_1011_1.s_literal", 32'(bus.s), 32'b1001);
        add_and_check("add_0111_0001_0", 4'b0111, 4'b0001, 1'b0);
        check("add_0111_0001_0.ovf_literal", 32'(bus.ovf), 32'd1);
        add_and_check("add_1111_0000_1", 4'b1111, 4'b0000, 1'b1);
        check("add_1111_0000_1.zero_literal", 32'(bus.zero), 32'd1);

        // Back-to-back, then idle with undriven operands
        add_and_check("b2b_first", 4'b0000, 4'b0000, 1'b0);
        add_and_check("b2b_second", 4'b0011, 4'b0100, 1'b1);
        check("b2b_second.s_literal", 32'(bus.s), 32'b1000);
        drive(1'b0, 'x, 'x, 1'bx);
        @(negedge clk);
        check("hold.out_valid", 32'(bus.out_valid), 32'd0);
        check("hold.s", 32'(bus.s), 32'b1000);
        check("hold.zero", 32'(bus.zero), 32'd0);
        @(negedge clk);
        check("hold2.s", 32'(bus.s), 32'b1000);

        // Asynchronous reset after launching an add in the same cycle
        drive(1'b1, 4'b1111, 4'b1111, 1'b1);
        #2 rst_n = 1'b0;
        #1 check_cleared("async_reset_immediate");
        @(negedge clk);
        check_cleared("async_reset_no_pulse");
        drive(1'b0, '0, '0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_cleared("after_release_idle");
        add_and_check("after_release_add", 4'b0011, 4'b0100, 1'b0);

        // Exhaustive sweep, back-to-back launches
        for (int i = 0; i < 2 ** (2 * W + 1); i++) begin
            vec = (2*W+1)'(i);
            add_and_check("exhaustive", vec[2*W:W+1], vec[W:1], vec[0]);
        end

        // Randomized spot checks with idle gaps between launches
        for (int i = 0; i < 32; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rc;
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom);
            add_and_check("random", ra, rb, rc);
            drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
            @(negedge clk);
            check("random_gap.out_valid", 32'(bus.out_valid), 32'd0);
            check("random_gap.s", 32'(bus.s), 32'(model(ra, rb, rc).s));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
